// File: rtl/match_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : match_sequencer_if
// Description : Control/status bundle between the match sequencer and the
//               rest of the game (input event pulses, scores, scene selects).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface match_sequencer_if;
    // Event pulses into the sequencer
    logic       frame_tick;
    logic       start_trigger;
    logic       pause_toggle;
    logic       exit_left;
    logic       exit_right;
    // Status out of the sequencer
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;
    logic       game_startup;
    logic       game_over;
    logic [2:0] state;

    // Producer of events / consumer of status
    modport master (
        output frame_tick, start_trigger, pause_toggle, exit_left, exit_right,
        input  score_p1, score_p2, ball_enable, ball_reset, serve_dir,
               game_startup, game_over, state
    );

    // The sequencer itself
    modport slave (
        input  frame_tick, start_trigger, pause_toggle, exit_left, exit_right,
        output score_p1, score_p2, ball_enable, ball_reset, serve_dir,
               game_startup, game_over, state
    );
endinterface

`default_nettype wire

// File: rtl/match_sequencer.sv
//------------------------------------------------------------------------------
// Module      : match_sequencer
// Description : Game flow controller: menu, serve delay, play, pause and
//               game-over hold, with score keeping and ball recentre pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module match_sequencer #(
    parameter int WIN_SCORE          = 7,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int OVER_HOLD_FRAMES   = 180
) (
    input  wire              clk_0,
    input  wire              rst,
    match_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_MENU       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] c_WIN_SCORE  = 4'(WIN_SCORE);
    localparam logic [7:0] c_SERVE_LAST = 8'(SERVE_DELAY_FRAMES - 1);
    localparam logic [7:0] c_OVER_HOLD  = 8'(OVER_HOLD_FRAMES);
    localparam logic [7:0] c_CNT_MAX    = 8'hFF;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_score_p1;
    logic [3:0] r_score_p2;
    logic       r_ball_enable;
    logic       r_ball_reset;
    logic       r_serve_dir;
    logic       r_game_startup;
    logic       r_game_over;

    logic [3:0] w_p1_inc;
    logic [3:0] w_p2_inc;

    assign w_p1_inc = r_score_p1 + 4'd1;
    assign w_p2_inc = r_score_p2 + 4'd1;

    // Match state machine; scene selects and motion enable are registered
    // alongside the state so they change on the same edge as the state.
    // Any transition overrides the frame counter back to zero.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_MENU;
            r_cnt          <= 8'd0;
            r_score_p1     <= 4'd0;
            r_score_p2     <= 4'd0;
            r_ball_enable  <= 1'b0;
            r_ball_reset   <= 1'b0;
            r_serve_dir    <= 1'b0;
            r_game_startup <= 1'b1;
            r_game_over    <= 1'b0;
        end else begin
            r_ball_reset <= 1'b0;
            if (bus.frame_tick && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 8'd1;
            end

            case (r_state)
                ST_MENU: begin
                    if (bus.start_trigger) begin
                        r_state        <= ST_SERVE_WAIT;
                        r_cnt          <= 8'd0;
                        r_score_p1     <= 4'd0;
                        r_score_p2     <= 4'd0;
                        r_serve_dir    <= 1'b0;
                        r_ball_reset   <= 1'b1;
                        r_game_startup <= 1'b0;
                    end
                end

                ST_SERVE_WAIT: begin
                    if (bus.frame_tick && (r_cnt == c_SERVE_LAST)) begin
                        r_state       <= ST_PLAY;
                        r_cnt         <= 8'd0;
                        r_ball_enable <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    // A point outranks a pause request; left exit outranks right.
                    if (bus.exit_left) begin
                        r_score_p2    <= w_p2_inc;
                        r_serve_dir   <= 1'b1;
                        r_ball_reset  <= 1'b1;
                        r_ball_enable <= 1'b0;
                        r_cnt         <= 8'd0;
                        if (w_p2_inc == c_WIN_SCORE) begin
                            r_state     <= ST_GAME_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= ST_SERVE_WAIT;
                        end
                    end else if (bus.exit_right) begin
                        r_score_p1    <= w_p1_inc;
                        r_serve_dir   <= 1'b0;
                        r_ball_reset  <= 1'b1;
                        r_ball_enable <= 1'b0;
                        r_cnt         <= 8'd0;
                        if (w_p1_inc == c_WIN_SCORE) begin
                            r_state     <= ST_GAME_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= ST_SERVE_WAIT;
                        end
                    end else if (bus.pause_toggle) begin
                        r_state       <= ST_PAUSED;
                        r_ball_enable <= 1'b0;
                        r_cnt         <= 8'd0;
                    end
                end

                ST_PAUSED: begin
                    if (bus.pause_toggle) begin
                        r_state       <= ST_PLAY;
                        r_ball_enable <= 1'b1;
                        r_cnt         <= 8'd0;
                    end
                end

                ST_GAME_OVER: begin
                    if (bus.start_trigger && (r_cnt >= c_OVER_HOLD)) begin
                        r_state        <= ST_MENU;
                        r_game_over    <= 1'b0;
                        r_game_startup <= 1'b1;
                        r_cnt          <= 8'd0;
                    end
                end

                default: begin
                    // Unused encodings fall back to the menu; scores untouched.
                    r_state        <= ST_MENU;
                    r_cnt          <= 8'd0;
                    r_ball_enable  <= 1'b0;
                    r_game_startup <= 1'b1;
                    r_game_over    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state        = r_state;
    assign bus.score_p1     = r_score_p1;
    assign bus.score_p2     = r_score_p2;
    assign bus.ball_enable  = r_ball_enable;
    assign bus.ball_reset   = r_ball_reset;
    assign bus.serve_dir    = r_serve_dir;
    assign bus.game_startup = r_game_startup;
    assign bus.game_over    = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_match_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_match_sequencer
// Description : Self-checking bench for match_sequencer: directed scenarios
//               followed by random event traffic against a rule-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_match_sequencer;

    localparam int WIN   = 3;
    localparam int SERVE = 3;
    localparam int HOLD  = 2;

    logic clk_0 = 1'b0;
    logic rst   = 1'b0;

    match_sequencer_if bus ();

    match_sequencer #(
        .WIN_SCORE          (WIN),
        .SERVE_DELAY_FRAMES (SERVE),
        .OVER_HOLD_FRAMES   (HOLD)
    ) dut (
        .clk_0 (clk_0),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk_0 = ~clk_0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase name, scores, serve side, frames since entry
    int m_state;
    int m_p1;
    int m_p2;
    int m_dir;
    int m_cnt;
    int m_breset;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_cnt = 0; m_breset = 0;
    endtask

    // Game rules applied to one clock's worth of input events
    task automatic model_step(input bit ft, input bit st, input bit pt,
                              input bit el, input bit er);
        int nxt;
        nxt = m_state;
        m_breset = 0;
        case (m_state)
            0: if (st) begin
                   m_p1 = 0; m_p2 = 0; m_dir = 0; m_breset = 1; nxt = 1;
               end
            1: if (ft && m_cnt == SERVE - 1) nxt = 2;
            2: begin
                   if (el) begin
                       m_p2 = m_p2 + 1; m_dir = 1; m_breset = 1;
                       nxt = (m_p2 == WIN) ? 4 : 1;
                   end else if (er) begin
                       m_p1 = m_p1 + 1; m_dir = 0; m_breset = 1;
                       nxt = (m_p1 == WIN) ? 4 : 1;
                   end else if (pt) begin
                       nxt = 3;
                   end
               end
            3: if (pt) nxt = 2;
            4: if (st && m_cnt >= HOLD) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_state) m_cnt = 0;
        else if (ft && m_cnt < 255) m_cnt = m_cnt + 1;
        m_state = nxt;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},   int'(bus.state),        m_state);
        chk({tag, ".p1"},      int'(bus.score_p1),     m_p1);
        chk({tag, ".p2"},      int'(bus.score_p2),     m_p2);
        chk({tag, ".dir"},     int'(bus.serve_dir),    m_dir);
        chk({tag, ".breset"},  int'(bus.ball_reset),   m_breset);
        chk({tag, ".enable"},  int'(bus.ball_enable),  (m_state == 2) ? 1 : 0);
        chk({tag, ".startup"}, int'(bus.game_startup), (m_state == 0) ? 1 : 0);
        chk({tag, ".over"},    int'(bus.game_over),    (m_state == 4) ? 1 : 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".state"},   int'(bus.state),        0);
        chk({tag, ".p1"},      int'(bus.score_p1),     0);
        chk({tag, ".p2"},      int'(bus.score_p2),     0);
        chk({tag, ".dir"},     int'(bus.serve_dir),    0);
        chk({tag, ".breset"},  int'(bus.ball_reset),   0);
        chk({tag, ".enable"},  int'(bus.ball_enable),  0);
        chk({tag, ".startup"}, int'(bus.game_startup), 1);
        chk({tag, ".over"},    int'(bus.game_over),    0);
    endtask

    // One clock: drive events, take the edge, advance the model, compare
    task automatic step(input string tag, input bit ft, input bit st,
                        input bit pt, input bit el, input bit er);
        bus.frame_tick    = ft;
        bus.start_trigger = st;
        bus.pause_toggle  = pt;
        bus.exit_left     = el;
        bus.exit_right    = er;
        @(posedge clk_0);
        model_step(ft, st, pt, el, er);
        #1;
        bus.frame_tick    = 1'b0;
        bus.start_trigger = 1'b0;
        bus.pause_toggle  = 1'b0;
        bus.exit_left     = 1'b0;
        bus.exit_right    = 1'b0;
        check_all(tag);
    endtask

    task automatic serve(input string tag);
        for (int i = 0; i < SERVE; i++) step(tag, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bus.frame_tick    = 1'b0;
        bus.start_trigger = 1'b0;
        bus.pause_toggle  = 1'b0;
        bus.exit_left     = 1'b0;
        bus.exit_right    = 1'b0;
        model_reset();

        // Held in reset across clock edges
        repeat (3) @(posedge clk_0);
        #1;
        check_reset_vals("rst_hold");
        rst = 1'b1;

        // First match: start, serve, points
        step("menu_idle", 0, 0, 0, 0, 0);
        step("start", 0, 1, 0, 0, 0);
        chk("start_breset", int'(bus.ball_reset), 1);
        chk("start_state", int'(bus.state), 1);
        step("after_start", 0, 0, 0, 0, 0);
        chk("breset_once", int'(bus.ball_reset), 0);
        step("pause_in_serve", 0, 0, 1, 1, 0);
        serve("serve1");
        chk("play_state", int'(bus.state), 2);
        chk("play_enable", int'(bus.ball_enable), 1);

        step("pt1", 0, 0, 0, 0, 1);
        chk("p1_is_1", int'(bus.score_p1), 1);
        serve("serve2");
        step("pt2", 0, 0, 0, 0, 1);
        chk("p1_is_2", int'(bus.score_p1), 2);
        serve("serve3");
        step("both_exits", 0, 0, 0, 1, 1);
        chk("both_p2", int'(bus.score_p2), 1);
        chk("both_p1", int'(bus.score_p1), 2);
        chk("both_dir", int'(bus.serve_dir), 1);
        serve("serve4");

        step("pause", 0, 0, 1, 0, 0);
        chk("paused_state", int'(bus.state), 3);
        step("paused_exit", 1, 0, 0, 1, 0);
        chk("paused_p2", int'(bus.score_p2), 1);
        step("resume", 0, 0, 1, 0, 0);
        chk("resume_state", int'(bus.state), 2);
        chk("resume_breset", int'(bus.ball_reset), 0);

        step("exit_and_pause", 0, 0, 1, 0, 1);
        chk("win_state", int'(bus.state), 4);
        chk("win_over", int'(bus.game_over), 1);
        chk("win_p1", int'(bus.score_p1), 3);

        // Game-over hold
        step("go_tick1", 1, 0, 0, 0, 0);
        step("go_early_start", 0, 1, 0, 0, 0);
        chk("go_early_state", int'(bus.state), 4);
        step("go_tick2", 1, 0, 0, 0, 0);
        step("go_start", 0, 1, 0, 0, 0);
        chk("go_menu_state", int'(bus.state), 0);
        chk("menu_keeps_p1", int'(bus.score_p1), 3);
        step("restart", 0, 1, 0, 0, 0);
        chk("restart_p1", int'(bus.score_p1), 0);
        chk("restart_p2", int'(bus.score_p2), 0);

        // Asynchronous reset in serve wait, asserted between edges
        step("sw_tick", 1, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(posedge clk_0);
        #1;
        rst = 1'b1;

        // Counter saturation: long game-over dwell must still allow restart
        step("sat_start", 0, 1, 0, 0, 0);
        for (int p = 0; p < WIN; p++) begin
            serve("sat_serve");
            step("sat_pt", 0, 0, 0, 1, 0);
        end
        chk("sat_over", int'(bus.state), 4);
        for (int i = 0; i < 300; i++) step("sat_tick", 1, 0, 0, 0, 0);
        step("sat_exit", 0, 1, 0, 0, 0);
        chk("sat_menu", int'(bus.state), 0);

        // Reset mid-play aborts the match
        step("rp_start", 0, 1, 0, 0, 0);
        serve("rp_serve");
        step("rp_pt", 0, 0, 0, 1, 0);
        serve("rp_serve2");
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_play");
        model_reset();
        @(posedge clk_0);
        #1;
        rst = 1'b1;
        step("rp_menu", 0, 0, 0, 1, 0);

        // Random event traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(99) < 40),
                 ($urandom_range(99) < 6),
                 ($urandom_range(99) < 5),
                 ($urandom_range(99) < 8),
                 ($urandom_range(99) < 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
